gpmc_ram_arbiter: RTL and testbench

// - Shares one single-port frame-buffer RAM between the GPMC host bridge and the internal display scan-out reader.
// - Sits between the synchronized GPMC host interface (cs/we/oe/address/data_out/data_in, all in clk domain) and the RAM.
// - Converts host strobe levels into single RAM cycles. Host has strict priority; scan-out uses a req/gnt handshake.

---
 rtl/gpmc_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_gpmc_ram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpmc_ram_arbiter.sv
// Purpose : shares one single-port frame-buffer RAM between the GPMC host bridge (strict priority)
//           and the display scan-out reader (req/gnt handshake).
// Latency : host write reaches RAM 2 cycles after the strobe edge; host_rdata valid 3 cycles after;
//           scan_gnt 1 cycle after an idle arbiter sees scan_req, scan_rvalid 1 cycle after scan_gnt.
// Backpressure: host strobes are never stalled; edges latch into pending flags (same-kind edge
//           before service overwrites address/data). scan_req waits, held, until scan_gnt.
//
// Ports:
//   clk, rst                      : sole clock, synchronous active-high reset
//   host_cs/we/oe (active low)    : synchronized bridge strobes
//   host_addr, host_wdata         : bridge address / write data
//   host_rdata                    : read data returned to the bridge, held until the next host read
//   scan_req, scan_addr           : scan-out read request (level) and address
//   scan_gnt, scan_rdata, scan_rvalid : accept pulse, read data, data-valid pulse
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata : single-port RAM, 1-cycle read latency
//
// Optional feature macro: GPMC_ARB_STATS_EN
//   Adds a 16-bit saturating count of cycles where scan_req is high but not granted.
//   Host read at address all-ones returns it (no RAM cycle); host write there clears it.
module gpmc_ram_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int RAM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      host_cs,
  input  logic                      host_we,
  input  logic                      host_oe,
  input  logic [ADDR_WIDTH-1:0]     host_addr,
  input  logic [DATA_WIDTH-1:0]     host_wdata,
  output logic [DATA_WIDTH-1:0]     host_rdata,
  input  logic                      scan_req,
  input  logic [RAM_ADDR_WIDTH-1:0] scan_addr,
  output logic                      scan_gnt,
  output logic [DATA_WIDTH-1:0]     scan_rdata,
  output logic                      scan_rvalid,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic [DATA_WIDTH-1:0]     ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    HOST_WR,
    HOST_RD,
    HOST_RD_WAIT,
    SCAN_RD
  } state_t;

  // Where a host read gets its data from; frozen in HOST_RD so a new oe edge
  // overwriting rd_addr_q cannot change the in-flight result.
  typedef enum logic [1:0] {
    SRC_RAM,
    SRC_ZERO,
    SRC_STATS
  } rd_src_t;

  state_t                  state_q, state_d;
  logic                    we_prev_q, we_prev_d;
  logic                    oe_prev_q, oe_prev_d;
  logic                    wr_pend_q, wr_pend_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  rd_src_t                 rd_src_q, rd_src_d;
  logic [DATA_WIDTH-1:0]   host_rdata_q, host_rdata_d;
  logic                    scan_rvalid_q, scan_rvalid_d;

  logic                    we_fall;
  logic                    oe_fall;
  logic                    wr_in_range;
  rd_src_t                 rd_src_cur;

`ifdef GPMC_ARB_STATS_EN
  logic [15:0]             stall_cnt_q, stall_cnt_d;
`endif

  assign we_fall     = !host_cs && we_prev_q && !host_we;
  assign oe_fall     = !host_cs && oe_prev_q && !host_oe;
  assign wr_in_range = (wr_addr_q[ADDR_WIDTH-1:RAM_ADDR_WIDTH] == '0);

  always_comb begin
    rd_src_cur = SRC_ZERO;
`ifdef GPMC_ARB_STATS_EN
    if (rd_addr_q == '1) begin
      rd_src_cur = SRC_STATS;
    end else
`endif
    if (rd_addr_q[ADDR_WIDTH-1:RAM_ADDR_WIDTH] == '0) begin
      rd_src_cur = SRC_RAM;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d       = state_q;
    we_prev_d     = host_we;
    oe_prev_d     = host_oe;
    wr_pend_d     = wr_pend_q;
    rd_pend_d     = rd_pend_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    rd_addr_d     = rd_addr_q;
    rd_src_d      = rd_src_q;
    host_rdata_d  = host_rdata_q;
    scan_rvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Pending flags are consumed at the decision point, so an edge landing
        // any later is kept as a fresh request instead of being cleared away.
        if (wr_pend_q) begin
          state_d   = HOST_WR;
          wr_pend_d = 1'b0;
        end else if (rd_pend_q) begin
          state_d   = HOST_RD;
          rd_pend_d = 1'b0;
        end else if (scan_req) begin
          state_d   = SCAN_RD;
        end
      end
      HOST_WR: begin
        state_d = IDLE;
      end
      HOST_RD: begin
        rd_src_d = rd_src_cur;
        state_d  = HOST_RD_WAIT;
      end
      HOST_RD_WAIT: begin
        case (rd_src_q)
          SRC_RAM:   host_rdata_d = ram_rdata;
`ifdef GPMC_ARB_STATS_EN
          SRC_STATS: host_rdata_d = DATA_WIDTH'(stall_cnt_q);
`endif
          default:   host_rdata_d = '0;
        endcase
        state_d = IDLE;
      end
      SCAN_RD: begin
        scan_rvalid_d = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // New strobe edges win over the clear above: never lose a request.
    if (we_fall) begin
      wr_pend_d = 1'b1;
      wr_addr_d = host_addr;
      wr_data_d = host_wdata;
    end
    if (oe_fall) begin
      rd_pend_d = 1'b1;
      rd_addr_d = host_addr;
    end
  end

`ifdef GPMC_ARB_STATS_EN
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == HOST_WR && wr_addr_q == '1) begin
      stall_cnt_d = '0;
    end else if (scan_req && !scan_gnt && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      we_prev_q     <= 1'b1;
      oe_prev_q     <= 1'b1;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_addr_q     <= '0;
      rd_src_q      <= SRC_ZERO;
      host_rdata_q  <= '0;
      scan_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_prev_q     <= we_prev_d;
      oe_prev_q     <= oe_prev_d;
      wr_pend_q     <= wr_pend_d;
      rd_pend_q     <= rd_pend_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_addr_q     <= rd_addr_d;
      rd_src_q      <= rd_src_d;
      host_rdata_q  <= host_rdata_d;
      scan_rvalid_q <= scan_rvalid_d;
    end
  end

  // RAM strobes decoded from the state; out-of-range and stats accesses
  // occupy their state slot but never touch the RAM.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      HOST_WR: begin
        if (wr_in_range) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = wr_addr_q[RAM_ADDR_WIDTH-1:0];
          ram_wdata = wr_data_q;
        end
      end
      HOST_RD: begin
        if (rd_src_cur == SRC_RAM) begin
          ram_en   = 1'b1;
          ram_addr = rd_addr_q[RAM_ADDR_WIDTH-1:0];
        end
      end
      SCAN_RD: begin
        ram_en   = 1'b1;
        ram_addr = scan_addr;
      end
      default: begin
        ram_en = 1'b0;
      end
    endcase
  end

  assign scan_gnt    = (state_q == SCAN_RD);
  assign scan_rvalid = scan_rvalid_q;
  // RAM data is forwarded in the cycle it appears so rvalid lands exactly one
  // cycle after gnt; gated to zero outside that cycle.
  assign scan_rdata  = scan_rvalid_q ? ram_rdata : '0;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_gpmc_ram_arbiter.sv
module tb_gpmc_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_cs, host_we, host_oe;
  logic [15:0] host_addr, host_wdata, host_rdata;
  logic        scan_req;
  logic [11:0] scan_addr;
  logic        scan_gnt, scan_rvalid;
  logic [15:0] scan_rdata;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  // Behavioural RAM seen by the DUT
  logic [15:0] ram_mem [0:4095];
  // Reference model of frame-buffer contents and bridge-visible read data
  logic [15:0] model_mem [0:4095];
  logic [15:0] model_rdata;

  int          en_cycles = 0;
  int          wr_cycles = 0;
  logic [11:0] last_wa;
  logic [15:0] last_wd;

  gpmc_ram_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .RAM_ADDR_WIDTH(12)
  ) dut (
    .clk(clk), .rst(rst),
    .host_cs(host_cs), .host_we(host_we), .host_oe(host_oe),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
    .scan_rdata(scan_rdata), .scan_rvalid(scan_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      en_cycles <= en_cycles + 1;
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_wdata;
        wr_cycles <= wr_cycles + 1;
        last_wa   <= ram_addr;
        last_wd   <= ram_wdata;
      end else begin
        ram_rdata <= ram_mem[ram_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write strobe; returns just after the edge that samples it.
  task automatic drive_we_edge(input logic [15:0] a, input logic [15:0] d);
    host_cs = 1'b0; host_we = 1'b0; host_addr = a; host_wdata = d;
    step();
    host_we = 1'b1; host_cs = 1'b1;
  endtask

  task automatic drive_oe_edge(input logic [15:0] a);
    host_cs = 1'b0; host_oe = 1'b0; host_addr = a;
    step();
    host_oe = 1'b1; host_cs = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; host_cs = 1'b1; host_we = 1'b1; host_oe = 1'b1;
    host_addr = '0; host_wdata = '0; scan_req = 1'b0; scan_addr = '0;
    repeat (3) step();
    checks++; if (host_rdata !== 16'h0) begin errors++; $display("FAIL reset_host_rdata: got %h want 0000", host_rdata); end
    checks++; if ({ram_en, ram_we, scan_gnt, scan_rvalid} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {ram_en, ram_we, scan_gnt, scan_rvalid}); end
    checks++; if (scan_rdata !== 16'h0) begin errors++; $display("FAIL reset_scan_rdata: got %h want 0000", scan_rdata); end
    rst = 1'b0;
    step();
    checks++; if ({ram_en, scan_gnt} !== 2'b0) begin errors++; $display("FAIL post_reset_idle: got %b want 00", {ram_en, scan_gnt}); end
    model_rdata = 16'h0;
  endtask

  task automatic test_write_read();
    int wc0;
    wc0 = wr_cycles;
    drive_we_edge(16'h0010, 16'hA5A5);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL wr_early: ram_en got %b want 0", ram_en); end
    step();
    checks++; if ({ram_en, ram_we} !== 2'b11) begin errors++; $display("FAIL wr_strobe: got %b want 11", {ram_en, ram_we}); end
    checks++; if (ram_addr !== 12'h010 || ram_wdata !== 16'hA5A5) begin errors++; $display("FAIL wr_addr_data: got %h/%h want 010/a5a5", ram_addr, ram_wdata); end
    step();
    checks++; if (wr_cycles !== wc0 + 1) begin errors++; $display("FAIL wr_count: got %0d want %0d", wr_cycles, wc0 + 1); end
    model_mem[12'h010] = 16'hA5A5;
    drive_oe_edge(16'h0010);
    step(); step();
    checks++; if (host_rdata !== model_rdata) begin errors++; $display("FAIL rd_early: got %h want %h", host_rdata, model_rdata); end
    step();
    model_rdata = model_mem[12'h010];
    checks++; if (host_rdata !== model_rdata) begin errors++; $display("FAIL rd_data: got %h want %h", host_rdata, model_rdata); end
    checks++; if (wr_cycles !== wc0 + 1) begin errors++; $display("FAIL rd_no_write: got %0d want %0d", wr_cycles, wc0 + 1); end
    step();
  endtask

  task automatic test_scan_priority();
    logic [15:0] d;
    d = 16'(($urandom & 16'hFFFF) | 16'h0001);
    drive_we_edge(16'h0020, d);
    scan_req = 1'b1; scan_addr = 12'h020;
    step();
    checks++; if (scan_gnt !== 1'b0 || {ram_en, ram_we} !== 2'b11) begin errors++; $display("FAIL scan_host_first: gnt %b en/we %b want 0/11", scan_gnt, {ram_en, ram_we}); end
    model_mem[12'h020] = d;
    step();
    checks++; if (scan_gnt !== 1'b0) begin errors++; $display("FAIL scan_gnt_early: got %b want 0", scan_gnt); end
    step();
    checks++; if (scan_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL scan_gnt: gnt %b en %b we %b want 1 1 0", scan_gnt, ram_en, ram_we); end
    scan_req = 1'b0;
    step();
    checks++; if (scan_rvalid !== 1'b1 || scan_rdata !== model_mem[12'h020]) begin errors++; $display("FAIL scan_rvalid: vld %b data %h want 1 %h", scan_rvalid, scan_rdata, model_mem[12'h020]); end
    step();
    checks++; if (scan_rvalid !== 1'b0 || scan_gnt !== 1'b0) begin errors++; $display("FAIL scan_pulse: vld %b gnt %b want 0 0", scan_rvalid, scan_gnt); end
  endtask

  task automatic test_simultaneous();
    host_cs = 1'b0; host_we = 1'b0; host_oe = 1'b0; host_addr = 16'h0030; host_wdata = 16'h1234;
    step();
    host_we = 1'b1; host_oe = 1'b1; host_cs = 1'b1;
    step();
    checks++; if ({ram_en, ram_we} !== 2'b11 || ram_addr !== 12'h030) begin errors++; $display("FAIL sim_write_first: en/we %b addr %h want 11 030", {ram_en, ram_we}, ram_addr); end
    model_mem[12'h030] = 16'h1234;
    step(); step(); step();
    checks++; if (host_rdata !== model_rdata) begin errors++; $display("FAIL sim_rd_early: got %h want %h", host_rdata, model_rdata); end
    step();
    model_rdata = model_mem[12'h030];
    checks++; if (host_rdata !== model_rdata) begin errors++; $display("FAIL sim_rd_data: got %h want %h", host_rdata, model_rdata); end
    step();
  endtask

  task automatic test_out_of_range();
    int en0;
    en0 = en_cycles;
    drive_we_edge(16'h2000, 16'hBEEF);
    repeat (3) step();
    checks++; if (en_cycles !== en0) begin errors++; $display("FAIL oor_write_dropped: ram cycles got %0d want %0d", en_cycles, en0); end
    drive_oe_edge(16'h2000);
    step(); step();
    checks++; if (host_rdata !== model_rdata) begin errors++; $display("FAIL oor_rd_early: got %h want %h", host_rdata, model_rdata); end
    step();
    model_rdata = 16'h0000;
    checks++; if (host_rdata !== model_rdata) begin errors++; $display("FAIL oor_rd_zero: got %h want 0000", host_rdata); end
    checks++; if (en_cycles !== en0) begin errors++; $display("FAIL oor_rd_no_ram: ram cycles got %0d want %0d", en_cycles, en0); end
    step();
  endtask

  task automatic test_busy_last_wins();
    int wc0;
    wc0 = wr_cycles;
    drive_oe_edge(16'h0010);
    host_cs = 1'b0; host_we = 1'b0; host_addr = 16'h0041; host_wdata = 16'h1111;
    step();
    host_we = 1'b1;
    step();
    host_we = 1'b0; host_addr = 16'h0042; host_wdata = 16'h2222;
    step();
    host_we = 1'b1; host_cs = 1'b1;
    repeat (4) step();
    model_rdata = model_mem[12'h010];
    model_mem[12'h042] = 16'h2222;
    checks++; if (wr_cycles !== wc0 + 1) begin errors++; $display("FAIL busy_one_write: got %0d want %0d", wr_cycles, wc0 + 1); end
    checks++; if (last_wa !== 12'h042 || last_wd !== 16'h2222) begin errors++; $display("FAIL busy_last_wins: got %h/%h want 042/2222", last_wa, last_wd); end
    checks++; if (host_rdata !== model_rdata) begin errors++; $display("FAIL busy_read: got %h want %h", host_rdata, model_rdata); end
  endtask

  task automatic test_reset_mid();
    int en0;
    drive_oe_edge(16'h0030);
    repeat (4) step();
    model_rdata = model_mem[12'h030];
    drive_oe_edge(16'h0010);
    step(); step();
    rst = 1'b1; scan_req = 1'b1; scan_addr = 12'h010;
    step();
    model_rdata = 16'h0000;
    checks++; if (host_rdata !== 16'h0 || {ram_en, scan_gnt, scan_rvalid} !== 3'b0) begin errors++; $display("FAIL rst_mid_outputs: rdata %h strobes %b want 0000 000", host_rdata, {ram_en, scan_gnt, scan_rvalid}); end
    step();
    rst = 1'b0;
    en0 = en_cycles;
    step();
    checks++; if (scan_gnt !== 1'b1) begin errors++; $display("FAIL rst_regrant: gnt got %b want 1", scan_gnt); end
    scan_req = 1'b0;
    step();
    checks++; if (scan_rvalid !== 1'b1 || scan_rdata !== model_mem[12'h010]) begin errors++; $display("FAIL rst_scan_data: vld %b data %h want 1 %h", scan_rvalid, scan_rdata, model_mem[12'h010]); end
    repeat (4) step();
    checks++; if (en_cycles !== en0 + 1 || host_rdata !== model_rdata) begin errors++; $display("FAIL rst_abandon: cycles %0d rdata %h want %0d %h", en_cycles, host_rdata, en0 + 1, model_rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int          op;
      logic [15:0] a, d;
      logic        inr;
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16'h1000, 16'hFFFE));
      else                           a = 16'($urandom_range(0, 16'h0FFF));
      d   = 16'($urandom & 16'hFFFF);
      inr = (a < 16'h1000);
      if (op == 0) begin
        drive_we_edge(a, d);
        step();
        checks++; if ({ram_en, ram_we} !== {inr, inr}) begin errors++; $display("FAIL rnd_wr_strobe[%0d]: got %b want %b", i, {ram_en, ram_we}, {inr, inr}); end
        if (inr) begin
          checks++; if (ram_addr !== a[11:0] || ram_wdata !== d) begin errors++; $display("FAIL rnd_wr_data[%0d]: got %h/%h want %h/%h", i, ram_addr, ram_wdata, a[11:0], d); end
          model_mem[a[11:0]] = d;
        end
        step(); step();
      end else if (op == 1) begin
        drive_oe_edge(a);
        step(); step(); step();
        model_rdata = inr ? model_mem[a[11:0]] : 16'h0000;
        checks++; if (host_rdata !== model_rdata) begin errors++; $display("FAIL rnd_rd[%0d] addr %h: got %h want %h", i, a, host_rdata, model_rdata); end
        step();
      end else begin
        scan_req = 1'b1; scan_addr = a[11:0];
        step();
        checks++; if (scan_gnt !== 1'b1) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b want 1", i, scan_gnt); end
        scan_req = 1'b0;
        step();
        checks++; if (scan_rvalid !== 1'b1 || scan_rdata !== model_mem[a[11:0]]) begin errors++; $display("FAIL rnd_scan[%0d] addr %h: vld %b data %h want 1 %h", i, a[11:0], scan_rvalid, scan_rdata, model_mem[a[11:0]]); end
        step();
      end
    end
  endtask

`ifdef GPMC_ARB_STATS_EN
  task automatic test_stats();
    int en0;
    en0 = en_cycles;
    drive_we_edge(16'hFFFF, 16'h0000);
    repeat (3) step();
    checks++; if (en_cycles !== en0) begin errors++; $display("FAIL stats_clear_no_ram: got %0d want %0d", en_cycles, en0); end
    // Each isolated request spends exactly one idle cycle waiting for its grant.
    for (int k = 0; k < 10; k++) begin
      scan_req = 1'b1; scan_addr = 12'(k);
      step();
      scan_req = 1'b0;
      step(); step();
    end
    en0 = en_cycles;
    drive_oe_edge(16'hFFFF);
    step(); step(); step();
    model_rdata = 16'h000A;
    checks++; if (host_rdata !== model_rdata) begin errors++; $display("FAIL stats_read: got %h want %h", host_rdata, model_rdata); end
    checks++; if (en_cycles !== en0) begin errors++; $display("FAIL stats_read_no_ram: got %0d want %0d", en_cycles, en0); end
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i]   = 16'h0000;
      model_mem[i] = 16'h0000;
    end
    ram_rdata = 16'h0000;
    last_wa   = '0;
    last_wd   = '0;
    test_reset();
    test_write_read();
    test_scan_priority();
    test_simultaneous();
    test_out_of_range();
    test_busy_last_wins();
    test_reset_mid();
    test_random();
`ifdef GPMC_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
